// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Registers the winning request onto the bus, holds it until m_ack, and aborts stuck transfers.
module mem_port_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 16,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hFFFF_FFFF)
) (
   input  logic              clk,
   input  logic              cpu_rst_n,
   input  logic              cpu_en,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              m_req,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack,
   output logic              bus_err
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_I = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;

   localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   // last_grant: 0 = fetch port, 1 = data port
   logic             last_grant;
   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic             i_elig;
   logic             d_elig;
   logic             grant_i;
   logic             grant_d;
   logic             timeout_hit;

   always_comb begin
      i_elig      = i_req && !i_done;
      d_elig      = d_req && !d_done;
      grant_i     = 1'b0;
      grant_d     = 1'b0;
      timeout_hit = (TIMEOUT != 0) && (count == CNT_MAX);
      if (state == IDLE && cpu_en) begin
         // A port that lost the previous tie wins the next one.
         if (i_elig && d_elig) begin
            grant_d = !last_grant;
            grant_i = last_grant;
         end else begin
            grant_i = i_elig;
            grant_d = d_elig;
         end
      end
   end

   always_ff @(posedge clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b0;
         count      <= '0;
         m_req      <= 1'b0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
         i_done     <= 1'b0;
         d_done     <= 1'b0;
         bus_err    <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  m_addr     <= d_addr;
                  m_we       <= d_we;
                  m_wdata    <= d_wdata;
                  m_req      <= 1'b1;
                  last_grant <= 1'b1;
                  count      <= '0;
                  state      <= BUSY_D;
               end else if (grant_i) begin
                  m_addr     <= i_addr;
                  m_we       <= 1'b0;
                  m_req      <= 1'b1;
                  last_grant <= 1'b0;
                  count      <= '0;
                  state      <= BUSY_I;
               end
            end
            BUSY_I, BUSY_D: begin
               // Ack wins over a timeout landing on the same edge.
               if (m_ack || timeout_hit) begin
                  if (state == BUSY_I) begin
                     i_done  <= 1'b1;
                     i_rdata <= m_ack ? m_rdata : ERR_DATA;
                  end else begin
                     d_done <= 1'b1;
                     if (!m_we) d_rdata <= m_ack ? m_rdata : ERR_DATA;
                  end
                  if (!m_ack) bus_err <= 1'b1;
                  m_req <= 1'b0;
                  m_we  <= 1'b0;
                  state <= IDLE;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter: the bench drives the memory ack/rdata by hand
// and every expected value below is worked out from the intended behaviour.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        cpu_en = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata = '0;
   logic        m_ack = 1'b0;
   logic        bus_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .ERR_DATA(32'hFFFF_FFFF)) dut (
      .clk(clk), .cpu_rst_n(cpu_rst_n), .cpu_en(cpu_en),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      cpu_rst_n = 1'b0;
      tick();
      cpu_rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      check("rst_m_req", m_req, 0);
      check("rst_m_we", m_we, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_i_done", i_done, 0);
      check("rst_d_done", d_done, 0);
      check("rst_bus_err", bus_err, 0);
      check("rst_i_rdata", i_rdata, 0);
      check("rst_d_rdata", d_rdata, 0);
      cpu_rst_n = 1'b1;

      // 1: single fetch, ack one cycle after m_req
      i_addr = 32'h0040_0000;
      i_req  = 1'b1;
      tick();
      check("t1_m_req", m_req, 1);
      check("t1_m_addr", m_addr, 32'h0040_0000);
      check("t1_m_we", m_we, 0);
      check("t1_no_done_yet", i_done, 0);
      m_ack   = 1'b1;
      m_rdata = 32'h2008_0005;
      tick();
      check("t1_i_done", i_done, 1);
      check("t1_i_rdata", i_rdata, 32'h2008_0005);
      check("t1_m_req_low", m_req, 0);
      i_req = 1'b0;
      m_ack = 1'b0;
      tick();
      check("t1_done_one_cycle", i_done, 0);
      check("t1_idle_ack_ignored", m_req, 0);

      // 2: simultaneous requests after reset, held; grants alternate D,I,D,I
      do_reset();
      i_addr = 32'h0000_0200;
      d_addr = 32'h0000_0100;
      d_we   = 1'b0;
      i_req  = 1'b1;
      d_req  = 1'b1;
      m_ack  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         m_rdata = 32'hA000_0000 + k;
         tick();
         check("t2_grant_req", m_req, 1);
         check("t2_grant_addr", m_addr, (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
         tick();
         check("t2_d_done", d_done, (k % 2 == 0) ? 1 : 0);
         check("t2_i_done", i_done, (k % 2 == 0) ? 0 : 1);
         if (k % 2 == 0) check("t2_d_rdata", d_rdata, 32'hA000_0000 + k);
         else            check("t2_i_rdata", i_rdata, 32'hA000_0000 + k);
      end
      i_req = 1'b0;
      d_req = 1'b0;
      m_ack = 1'b0;
      tick();

      // 3: data write, three wait cycles, inputs wiggled during BUSY
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0010;
      d_wdata = 32'hCAFE_0001;
      m_rdata = 32'hDEAD_BEEF;
      tick();
      check("t3_m_we", m_we, 1);
      check("t3_m_addr", m_addr, 32'h0000_0010);
      check("t3_m_wdata", m_wdata, 32'hCAFE_0001);
      d_addr  = 32'h0000_0BAD;
      d_wdata = 32'h1111_2222;
      d_we    = 1'b0;
      for (int w = 0; w < 3; w++) begin
         tick();
         check("t3_hold_req", m_req, 1);
         check("t3_hold_we", m_we, 1);
         check("t3_hold_addr", m_addr, 32'h0000_0010);
         check("t3_hold_wdata", m_wdata, 32'hCAFE_0001);
         check("t3_no_done", d_done, 0);
      end
      m_ack = 1'b1;
      tick();
      check("t3_d_done", d_done, 1);
      check("t3_d_rdata_kept", d_rdata, 32'hA000_0002);
      check("t3_m_we_low", m_we, 0);
      d_req = 1'b0;
      m_ack = 1'b0;
      tick();

      // 4: fetch with no ack times out on the 16th BUSY cycle
      i_addr = 32'h0000_0300;
      i_req  = 1'b1;
      tick();
      check("t4_m_req", m_req, 1);
      for (int c = 0; c < 15; c++) begin
         tick();
         check("t4_waiting", i_done, 0);
      end
      tick();
      check("t4_i_done", i_done, 1);
      check("t4_i_rdata_err", i_rdata, 32'hFFFF_FFFF);
      check("t4_bus_err", bus_err, 1);
      check("t4_m_req_low", m_req, 0);
      i_req = 1'b0;
      tick();
      check("t4_bus_err_sticky", bus_err, 1);
      check("t4_done_one_cycle", i_done, 0);

      // 5: cpu_en gating of new grants only
      cpu_en = 1'b0;
      i_req  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("t5_no_grant", m_req, 0);
      end
      i_req  = 1'b0;
      cpu_en = 1'b1;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_0020;
      tick();
      check("t5_grant_d", m_req, 1);
      cpu_en = 1'b0;
      tick();
      check("t5_busy_held", m_req, 1);
      m_ack   = 1'b1;
      m_rdata = 32'h5555_AAAA;
      tick();
      check("t5_d_done", d_done, 1);
      check("t5_d_rdata", d_rdata, 32'h5555_AAAA);
      d_req  = 1'b0;
      m_ack  = 1'b0;
      cpu_en = 1'b1;
      tick();

      // 6: asynchronous reset mid-transfer, then D granted on the first edge
      i_req  = 1'b1;
      i_addr = 32'h0000_0400;
      tick();
      check("t6_busy", m_req, 1);
      cpu_rst_n = 1'b0;
      i_req     = 1'b0;
      d_req     = 1'b1;
      d_addr    = 32'h0000_0500;
      #1;
      check("t6_async_m_req", m_req, 0);
      check("t6_async_i_done", i_done, 0);
      check("t6_async_bus_err", bus_err, 0);
      #3;
      cpu_rst_n = 1'b1;
      tick();
      check("t6_first_grant", m_req, 1);
      check("t6_first_addr", m_addr, 32'h0000_0500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
